// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: programs N, M and NUM_C post-scale C counters of an
// ALTPLL through the ALTPLL_RECONFIG scan-chain interface in one transaction.
// Ports: clock_ctr/sys_reset (sync, active-high); start/ready handshake with
// n_val/m_val/c_val; done pulse and sticky error; counter_type_ctr,
// counter_param_ctr, config_data_in, write_param_ctr, reconfig_ctr,
// reset_ctr, pll_areset_in_ctr toward the reconfig block; busy_ctr from it.
// Optional busy-wait watchdog: define PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_seq #(
  parameter int NUM_C        = 1,
  parameter int SETUP_CYC    = 5,
  parameter int WRITE_CYC    = 10,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic             clock_ctr,
  input  logic             sys_reset,
  input  logic             start,
  input  logic [7:0]       n_val,
  input  logic [7:0]       m_val,
  input  logic [8*NUM_C-1:0] c_val,
  output logic             ready,
  output logic             done,
  output logic             error,
  output logic [3:0]       counter_type_ctr,
  output logic [2:0]       counter_param_ctr,
  output logic [8:0]       config_data_in,
  output logic             write_param_ctr,
  output logic             reconfig_ctr,
  output logic             reset_ctr,
  output logic             pll_areset_in_ctr,
  input  logic             busy_ctr
);

  if (NUM_C < 1 || NUM_C > 8 || SETUP_CYC < 1 ||
      WRITE_CYC < 1 || BUSY_TIMEOUT < 1) begin : g_bad_param
    $error("pll_reconfig_seq: parameter out of range");
  end

  localparam int KW = $clog2(NUM_C + 2);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_C + 1);

  typedef enum logic [3:0] {
    S_RST, S_RST_PLL, S_RST_REC, S_IDLE, S_CHECK, S_SETUP,
    S_WRITE, S_WWAIT, S_RECONF, S_RWAIT, S_DONE, S_TO_RST
  } state_t;

  state_t state, state_n;
  logic [15:0] cnt, cnt_ld;
  logic [KW-1:0] k;
  logic phase;
  logic [7:0] n_sh, m_sh;
  logic [8*NUM_C-1:0] c_sh;
  logic [7:0] cur_v;
  logic any_zero, one_wr, last_wr, last_ctr, active, to_hit;

  // value of the counter currently being written (k: 0=N, 1=M, 2+i=Ci)
  always_comb begin
    cur_v = n_sh;
    if (k == KW'(1)) cur_v = m_sh;
    for (int i = 0; i < NUM_C; i++)
      if (int'(k) == i + 2) cur_v = c_sh[8*i +: 8];
  end

  always_comb begin
    any_zero = (n_sh == 8'd0) || (m_sh == 8'd0);
    for (int i = 0; i < NUM_C; i++)
      if (c_sh[8*i +: 8] == 8'd0) any_zero = 1'b1;
  end

  assign one_wr   = (cur_v == 8'd1);
  assign last_wr  = one_wr || phase;
  assign last_ctr = (k == K_LAST);

`ifdef PLL_RECONFIG_TIMEOUT_EN
  logic [15:0] wd;
  logic in_wait;
  assign in_wait = (state == S_WWAIT) || (state == S_RWAIT);
  assign to_hit  = in_wait && busy_ctr && (wd == 16'(BUSY_TIMEOUT - 1));
  always_ff @(posedge clock_ctr) begin
    if (sys_reset || !(in_wait && busy_ctr)) wd <= '0;
    else wd <= wd + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_RST:     state_n = S_RST_PLL;
      S_RST_PLL: state_n = S_RST_REC;
      S_RST_REC: if (cnt == '0) state_n = S_IDLE;
      S_IDLE:    if (start) state_n = S_CHECK;
      S_CHECK:   state_n = any_zero ? S_IDLE : S_SETUP;
      S_SETUP:   if (cnt == '0) state_n = S_WRITE;
      S_WRITE:   state_n = S_WWAIT;
      S_WWAIT:
        if (cnt == '0 && !busy_ctr)
          state_n = (last_wr && last_ctr) ? S_RECONF : S_SETUP;
      S_RECONF:  state_n = S_RWAIT;
      S_RWAIT:   if (cnt == '0 && !busy_ctr) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      S_TO_RST:  if (cnt == '0) state_n = S_IDLE;
      default:   state_n = S_RST;
    endcase
    if (to_hit) state_n = S_TO_RST;
  end

  // delay reload value for the state being entered
  always_comb begin
    cnt_ld = '0;
    unique case (state_n)
      S_SETUP:             cnt_ld = 16'(SETUP_CYC - 1);
      S_WWAIT:             cnt_ld = 16'(WRITE_CYC - 1);
      S_RWAIT:             cnt_ld = 16'd1;
      S_RST_REC, S_TO_RST: cnt_ld = 16'd9;
      default:             cnt_ld = '0;
    endcase
  end

  always_ff @(posedge clock_ctr) begin
    if (sys_reset) begin
      state <= S_RST;
      cnt   <= '0;
      k     <= '0;
      phase <= 1'b0;
      error <= 1'b0;
      n_sh  <= '0;
      m_sh  <= '0;
      c_sh  <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= cnt_ld;
      else if (cnt != '0) cnt <= cnt - 16'd1;
      if (state == S_IDLE && start) begin
        n_sh  <= n_val;
        m_sh  <= m_val;
        c_sh  <= c_val;
        error <= 1'b0;
        k     <= '0;
        phase <= 1'b0;
      end
      if (state == S_CHECK && any_zero) error <= 1'b1;
      if (state == S_WWAIT && state_n == S_SETUP) begin
        if (last_wr) begin
          k     <= k + KW'(1);
          phase <= 1'b0;
        end else begin
          phase <= 1'b1;
        end
      end
      if (to_hit) error <= 1'b1;
    end
  end

  // scan-chain fields follow k/phase, so they hold through the tail states
  assign active = state inside {S_SETUP, S_WRITE, S_WWAIT,
                                S_RECONF, S_RWAIT, S_DONE};

  always_comb begin
    counter_type_ctr  = 4'b0000;
    counter_param_ctr = 3'b000;
    config_data_in    = 9'd0;
    if (active) begin
      counter_type_ctr = (k < KW'(2)) ? 4'(k) : 4'(k) + 4'd2;
      if (one_wr) begin
        counter_param_ctr = 3'b100;
        config_data_in    = 9'd1;
      end else if (phase) begin
        counter_param_ctr = 3'b001;
        config_data_in    = {2'b00, cur_v[7:1]};
      end else begin
        counter_param_ctr = 3'b000;
        config_data_in    = {1'b0, {1'b0, cur_v[7:1]} + {7'd0, cur_v[0]}};
      end
    end
  end

  assign ready             = (state == S_IDLE);
  assign done              = (state == S_DONE);
  assign write_param_ctr   = (state == S_WRITE);
  assign reconfig_ctr      = (state == S_RECONF);
  assign pll_areset_in_ctr = (state == S_RST_PLL);
  assign reset_ctr         = (state == S_RST_REC) || (state == S_TO_RST);

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed + randomized transactions on pll_reconfig_seq
// against a write-list model built from counter values.
module tb_pll_reconfig_seq;
  localparam int NC = 2;
  localparam int SC = 5;
  localparam int WC = 10;
  localparam int BT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy;
  logic [7:0] n_v, m_v;
  logic [8*NC-1:0] c_v;
  logic ready, done, error, wp, rc, rctr, are;
  logic [3:0] ctype;
  logic [2:0] cparam;
  logic [8:0] cdata;

  int total = 0;
  int bad = 0;

  pll_reconfig_seq #(
    .NUM_C(NC), .SETUP_CYC(SC), .WRITE_CYC(WC), .BUSY_TIMEOUT(BT)
  ) dut (
    .clock_ctr(clk), .sys_reset(rst), .start(start),
    .n_val(n_v), .m_val(m_v), .c_val(c_v),
    .ready(ready), .done(done), .error(error),
    .counter_type_ctr(ctype), .counter_param_ctr(cparam),
    .config_data_in(cdata), .write_param_ctr(wp),
    .reconfig_ctr(rc), .reset_ctr(rctr),
    .pll_areset_in_ctr(are), .busy_ctr(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] wq[$];
  int wcyc[$], wstab[$], rcyc[$], dcyc[$];
  logic [15:0] last_cfg = '0;
  int stab = 0;

  always @(negedge clk) begin
    logic [15:0] cur;
    cur = {ctype, cparam, cdata};
    if (cur == last_cfg) stab++;
    else stab = 1;
    last_cfg = cur;
    if (wp) begin
      wq.push_back(cur);
      wcyc.push_back(cyc);
      wstab.push_back(stab);
    end
    if (rc) rcyc.push_back(cyc);
    if (done) dcyc.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // write list from the counter values: ceil(v/2) high, floor(v/2) low
  task automatic model(input logic [7:0] n, input logic [7:0] m,
                       input logic [8*NC-1:0] c);
    int v;
    logic [3:0] t;
    exp_q.delete();
    for (int j = 0; j < NC + 2; j++) begin
      if (j == 0) v = n;
      else if (j == 1) v = m;
      else v = c[8*(j-2) +: 8];
      t = (j < 2) ? 4'(j) : 4'(4 + (j - 2));
      if (v == 1) exp_q.push_back({t, 3'b100, 9'd1});
      else begin
        exp_q.push_back({t, 3'b000, 9'((v + 1) / 2)});
        exp_q.push_back({t, 3'b001, 9'(v / 2)});
      end
    end
  endtask

  task automatic clr_q();
    wq.delete(); wcyc.delete(); wstab.delete();
    rcyc.delete(); dcyc.delete();
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, ready, done, error, ctype, cparam, cdata,
            wp, rc, rctr, are};
  endfunction

  // rst has just been dropped; watch the release sequence
  task automatic reset_seq(input string tag);
    int a_first = -1, a_n = 0, r_first = -1, r_n = 0, rdy = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (are) begin a_n++; if (a_first < 0) a_first = i; end
      if (rctr) begin r_n++; if (r_first < 0) r_first = i; end
      if (ready && rdy < 0) rdy = i;
    end
    chk({tag, "_areset_first"}, a_first, 0);
    chk({tag, "_areset_len"}, a_n, 1);
    chk({tag, "_rstctr_first"}, r_first, 1);
    chk({tag, "_rstctr_len"}, r_n, 10);
    chk({tag, "_ready_first"}, rdy, 11);
  endtask

  task automatic launch(input logic [7:0] n, input logic [7:0] m,
                        input logic [8*NC-1:0] c);
    int w = 0;
    clr_q();
    while (!ready && w < 300) begin tick(); w++; end
    chk("ready_before_start", ready, 1);
    n_v = n; m_v = m; c_v = c; start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_clears_error", error, 0);
    chk("ready_low_after_accept", ready, 0);
    n_v = 8'($urandom); m_v = 8'($urandom); c_v = 16'($urandom);
  endtask

  // mode 0: busy low, exact timing; 1: busy 50 cycles after 2nd write;
  // 2: random busy
  task automatic run_txn(input logic [7:0] n, input logic [7:0] m,
                         input logic [8*NC-1:0] c, input int mode);
    bit zero;
    int w;
    zero = (n == 0) || (m == 0);
    for (int j = 0; j < NC; j++) if (c[8*j +: 8] == 0) zero = 1'b1;
    launch(n, m, c);
    if (zero) begin
      tick();
      chk("zero_error", error, 1);
      chk("zero_ready", ready, 1);
      repeat (30) tick();
      chk("zero_no_writes", wq.size(), 0);
      chk("zero_no_done", dcyc.size(), 0);
      chk("zero_error_sticky", error, 1);
      return;
    end
    model(n, m, c);
    if (mode == 1) begin
      w = 0;
      while (wq.size() < 2 && w < 500) begin tick(); w++; end
      busy = 1'b1;
      repeat (50) tick();
      busy = 1'b0;
    end
    w = 0;
    while (dcyc.size() == 0 && w < 5000) begin
      if (mode == 2) busy = ($urandom_range(0, 3) == 0);
      tick();
      w++;
    end
    busy = 1'b0;
    tick();
    chk("done_count", dcyc.size(), 1);
    chk("reconf_count", rcyc.size(), 1);
    chk("write_count", wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      chk($sformatf("write_cfg%0d", i), wq[i], exp_q[i]);
      chk($sformatf("setup_len%0d", i), wstab[i], SC + 1);
    end
    if (rcyc.size() == 1 && dcyc.size() == 1 && wcyc.size() > 0) begin
      if (mode == 0) begin
        for (int i = 1; i < wcyc.size(); i++)
          chk($sformatf("write_gap%0d", i), wcyc[i] - wcyc[i-1], SC + WC + 1);
        chk("reconf_after_write", rcyc[0] - wcyc[wcyc.size()-1], WC + 1);
        chk("done_after_reconf", dcyc[0] - rcyc[0], 3);
      end else begin
        chk("done_after_reconf_min", (dcyc[0] - rcyc[0]) >= 3, 1);
      end
    end
    if (mode == 1 && wcyc.size() >= 3)
      chk("busy_hold_gap", (wcyc[2] - wcyc[1]) > 50, 1);
    chk("end_error", error, 0);
    chk("end_ready", ready, 1);
  endtask

  initial begin
    int w;
    logic [7:0] rn, rm;
    logic [15:0] rcv;
    rst = 1'b1; start = 1'b0; busy = 1'b0;
    n_v = '0; m_v = '0; c_v = '0;
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    reset_seq("rel");

    run_txn(8'd1, 8'd20, {8'd3, 8'd7}, 0);
    run_txn(8'd9, 8'd4, {8'd1, 8'd200}, 1);
    run_txn(8'd5, 8'd0, {8'd2, 8'd2}, 0);
    run_txn(8'd255, 8'd2, {8'd128, 8'd1}, 0);

    for (int r = 0; r < 6; r++) begin
      rn = 8'($urandom_range(1, 255));
      rm = 8'($urandom_range(1, 255));
      rcv = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      if (r == 1) rn = 8'd1;
      if (r == 2) rcv[15:8] = 8'd1;
      if (r == 3) rcv[15:8] = 8'd0;
      run_txn(rn, rm, rcv, (r == 4) ? 2 : 0);
    end

    // reset during the 3rd SETUP
    launch(8'd6, 8'd11, {8'd9, 8'd3});
    w = 0;
    while (wq.size() < 2 && w < 500) begin tick(); w++; end
    repeat (WC + 2) tick();
    chk("abort_in_setup_writes", wq.size(), 2);
    rst = 1'b1;
    tick();
    chk("abort_outputs", outs(), 0);
    tick();
    rst = 1'b0;
    reset_seq("abort");
    repeat (40) tick();
    chk("abort_no_more_writes", wq.size(), 2);
    chk("abort_no_done", dcyc.size(), 0);

`ifdef PLL_RECONFIG_TIMEOUT_EN
    busy = 1'b1;
    launch(8'd3, 8'd3, {8'd3, 8'd3});
    w = 0;
    while (!error && w < 500) begin tick(); w++; end
    chk("to_error", error, 1);
    chk("to_one_write", wq.size(), 1);
    if (wcyc.size() > 0) chk("to_latency", cyc - wcyc[0], BT + 1);
    w = 0;
    while (rctr && w < 20) begin w++; tick(); end
    chk("to_rstctr_len", w, 10);
    chk("to_ready", ready, 1);
    chk("to_no_done", dcyc.size(), 0);
    busy = 1'b0;
    run_txn(8'd2, 8'd3, {8'd4, 8'd5}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
